// File: rtl/allgather_eject_collector.sv
// allgather_eject_collector
// Node-side receiver for AllGather packets from a router ejection port.
// Filters packets by context and collective type, stores one payload per
// rank, and raises a done pulse once every rank of the communicator has
// contributed. The gathered vector stays frozen for host readout until ack.
//
// Handshake: a packet is consumed on a rising edge where eject_ready is high
// and eject_pkt[81] (valid) is set. Only one packet is consumed per cycle.
// eject_ready depends only on the state, never on the packet, so the sender
// may hold a packet for as long as it likes without a combinational loop.
module allgather_eject_collector #(
  parameter int PKT_W  = 84,
  parameter int DATA_W = 32,
  parameter int LG_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PKT_W-1:0]  eject_pkt,
  output logic              eject_ready,
  input  logic [7:0]        my_context,
  input  logic [3:0]        lg_commsize,
  input  logic [8:0]        local_rank,
  input  logic [DATA_W-1:0] local_data,
  input  logic              start,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  input  logic [LG_MAX-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              err_dup,
  output logic              err_range,
  output logic [7:0]        drop_cnt,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << LG_MAX;

  localparam logic [3:0] TYPE_SHORT_AG = 4'b1010;
  localparam logic [3:0] TYPE_LARGE_AG = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  logic [DEPTH-1:0]  r_bitmap;
  logic [LG_MAX:0]   r_commsize;
  logic              r_done;
  logic              r_err_dup;
  logic              r_err_range;
  logic [7:0]        r_drop_cnt;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_buf [DEPTH];

  // Packet field decode
  logic [3:0]        w_type;
  logic [7:0]        w_ctx;
  logic [7:0]        w_index;
  logic [DATA_W-1:0] w_payload;
  logic [LG_MAX-1:0] w_slot;
  logic [LG_MAX-1:0] w_local_slot;
  logic              w_consume;
  logic              w_match;
  logic              w_in_range;
  logic              w_dup;
  logic              w_accept;
  logic              w_start_ok;
  logic [LG_MAX:0]   w_pop;
  logic              w_full;
  logic              w_unused_bits;

  assign w_type       = eject_pkt[35:32];
  assign w_ctx        = eject_pkt[53:46];
  assign w_index      = eject_pkt[45:38];
  assign w_payload    = eject_pkt[DATA_W-1:0];
  assign w_slot       = w_index[LG_MAX-1:0];
  assign w_local_slot = local_rank[LG_MAX-1:0];

  // Routing/header fields are not needed at the endpoint
  assign w_unused_bits = ^{eject_pkt[PKT_W-1:82], eject_pkt[80:54], eject_pkt[37:36],
                           w_index[7:LG_MAX], local_rank[8:LG_MAX]};

  assign w_consume  = (r_state == S_COLLECT) && eject_pkt[81];
  assign w_match    = ((w_type == TYPE_SHORT_AG) || (w_type == TYPE_LARGE_AG)) &&
                      (w_ctx == my_context);
  assign w_in_range = (32'(w_index) < 32'(r_commsize));
  assign w_dup      = r_bitmap[w_slot];
  assign w_accept   = w_consume && w_match && w_in_range && !w_dup;
  assign w_start_ok = start && (32'(lg_commsize) <= LG_MAX);

  // Population count of the registered bitmap for the completion check
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_pop = w_pop + (LG_MAX+1)'(r_bitmap[i]);
    end
  end

  assign w_full = (w_pop == r_commsize);

  // Control FSM: arming, packet classification, completion and release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_bitmap    <= '0;
      r_commsize  <= '0;
      r_done      <= 1'b0;
      r_err_dup   <= 1'b0;
      r_err_range <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err_dup  <= 1'b0;
            r_drop_cnt <= '0;
            if (w_start_ok) begin
              r_commsize  <= (LG_MAX+1)'(1) << lg_commsize;
              r_bitmap    <= DEPTH'(1) << w_local_slot;
              r_err_range <= 1'b0;
              r_state     <= S_COLLECT;
            end else begin
              r_err_range <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          // Completion looks at the bitmap as registered before this edge
          if (w_full) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
          if (w_consume) begin
            if (!w_match) begin
              if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
              end
            end else if (!w_in_range) begin
              r_err_range <= 1'b1;
            end else if (w_dup) begin
              r_err_dup <= 1'b1;
            end else begin
              r_bitmap[w_slot] <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (ack) begin
            r_bitmap <= '0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gather buffer: local contribution on arm, remote payloads on accept
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && w_start_ok) begin
      r_buf[w_local_slot] <= local_data;
    end else if (w_accept) begin
      r_buf[w_slot] <= w_payload;
    end
  end

  // Registered read port; same-edge write is seen on a later read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data <= r_buf[rd_idx];
      end
    end
  end

  assign eject_ready = (r_state == S_COLLECT);
  assign busy        = (r_state == S_COLLECT);
  assign done        = r_done;
  assign err_dup     = r_err_dup;
  assign err_range   = r_err_range;
  assign drop_cnt    = r_drop_cnt;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign dbg_state   = r_state;

endmodule
